wb_protocol_monitor: RTL and testbench
======================================

# wb_protocol_monitor

Synthesizable, parametrised Wishbone classic-cycle protocol monitor for the SDRAM agent environment. It passively observes one master/slave Wishbone link and tracks each transfer with a state machine. It detects handshake violations (stray ack, early strobe drop, ack timeout, request instability) and keeps per-direction transfer counts and worst-case ack latency. Results go to sticky status registers, so the checks also run on FPGA or in gate-level simulation, where assertion-only checking is not available.

## Interface
Parameters:
- AW, 24: observed address width.
- TIMEOUT, 16: maximum cycles from request to ack; must be ≥ 2.
- CNT_W, 16: width of the transfer counters.
- LAT_W, $clog2(TIMEOUT+1): width of the latency register (derived).

Ports:
- clk_i  in  1  Wishbone clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cyc_i  in  1  observed CYC.
- stb_i  in  1  observed STB.
- we_i  in  1  observed WE.
- adr_i  in  AW  observed address.
- ack_i  in  1  observed slave ACK.
- clr_i  in  1  synchronous clear of all status (flags, counters, max_lat_o); does not affect the FSM.
- err_o  out  4  sticky violation flags: [0] stray ack, [1] early strobe drop, [2] timeout, [3] request changed.
- irq_o  out  1  registered OR of err_o.
- rd_cnt_o  out  CNT_W  completed reads; saturating.
- wr_cnt_o  out  CNT_W  completed writes; saturating.
- max_lat_o  out  LAT_W  largest ack latency seen, in cycles (0 = ack in the request cycle).
- busy_o  out  1  high while the FSM is in WAIT or TOUT.

## Operation
- Request: cyc_i & stb_i. Completion: request & ack_i in the same cycle.
- FSM states: IDLE, WAIT, TOUT.
- IDLE:
  - Request with ack: count the transfer, latency 0, stay in IDLE.
  - Request without ack: capture adr_i/we_i, set lat_cnt = 1, go to WAIT.
  - ack_i without request: set err[0].
- WAIT:
  - Completion: count per the captured we, update max_lat with lat_cnt, go to IDLE.
  - stb_i or cyc_i low without ack: set err[1], go to IDLE; no count.
  - adr_i or we_i differs from the captured value while request is held: set err[3], stay in WAIT.
  - Otherwise increment lat_cnt. When lat_cnt reaches TIMEOUT without ack: set err[2], go to TOUT.
- TOUT:
  - Exits to IDLE on ack_i or on request drop.
  - A late ack is not counted and does not update max_lat.
  - No err[1] or err[3] checks in this state.
- Back-to-back transfers: a request still high in the cycle after completion is a new transfer; it is evaluated from IDLE that cycle.
- Counters and max_lat:
  - Counters saturate at all-ones and never wrap.
  - max_lat updates only when the new latency is strictly greater.
- clr_i in the same cycle as an event: the event wins. A flag set that cycle stays 1; a counter increment that cycle loads 1.

## Timing
- Reset values: all outputs 0, FSM in IDLE, lat_cnt = 0, captured adr/we = 0.
- Reset asserted mid-transfer returns the FSM to IDLE immediately. No flag is raised for the aborted transfer.
- Detection latency: flags, counters and max_lat_o update on the clock edge that samples the event, so they are visible one cycle after the event cycle.
- irq_o follows err_o with one more register stage: visible two cycles after the event.
- busy_o is registered from the FSM state.
- Latency measure: a transfer whose request starts in cycle N and acks in cycle N+k reports k.
- Timeout fires at the edge where k would reach TIMEOUT with no ack seen.

## Configuration
- WB_MON_ASSERT_EN defined: adds concurrent SVA assertions, one per err bit, each firing in the same cycle its flag-set condition is sampled. Also adds cover properties for completed read, completed write, and TOUT entry, with messages prefixed "[WB_MON]".
- Undefined: no SVA is compiled. RTL behaviour and all outputs are identical, and the block is fully synthesizable.

## Test plan
All scenarios use TIMEOUT = 4 and AW = 24.
- Single write with ack 2 cycles after the request → wr_cnt_o = 1, max_lat_o = 2, err_o = 0, busy_o high for exactly 2 cycles.
- Ack arriving with no cyc_i/stb_i → err_o = 4'b0001, then irq_o = 1 one cycle later. clr_i pulse → err_o = 0, irq_o = 0.
- Read request held with no ack → err_o[2] = 1 four cycles after the request. Then an ack in TOUT → FSM returns to IDLE, rd_cnt_o = 0.
- Request pending; adr_i changes from 0x000100 to 0x000104 in cycle 1 → err_o[3] = 1. Ack in cycle 2 still counts: rd_cnt_o = 1.
- stb_i drops at cycle 1 with no ack → err_o[1] = 1, no count. Separately, 3 back-to-back zero-wait writes → wr_cnt_o = 3, max_lat_o = 0.
- With CNT_W = 2: 5 reads → rd_cnt_o = 3 (saturated). rst_i asserted mid-WAIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone classic-cycle monitor: tracks each transfer, flags handshake violations,
// counts completed transfers and records worst-case ack latency. WB_MON_ASSERT_EN adds SVA checks/covers.
module wb_protocol_monitor #(
    parameter int AW      = 24,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16,
    parameter int LAT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [AW-1:0]    adr_i,
    input  logic             ack_i,
    input  logic             clr_i,
    output logic [3:0]       err_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [LAT_W-1:0] max_lat_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TOUT = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    state_t             state_q, state_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic               we_q, we_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [3:0]         err_q, err_d;
    logic               irq_q, irq_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LAT_W-1:0]   max_lat_q, max_lat_d;

    logic               req;
    logic [3:0]         err_set;
    logic               rd_done;
    logic               wr_done;
    logic               lat_upd;
    logic [LAT_W-1:0]   lat_val;
    logic [LAT_W-1:0]   max_base;

    assign req = cyc_i & stb_i;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] r;
        if (inc) begin
            if (clr)       r = CNT_W'(1);
            else if (&cnt) r = cnt;
            else           r = cnt + CNT_W'(1);
        end else begin
            r = clr ? '0 : cnt;
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        lat_d   = lat_q;
        err_set = '0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        lat_upd = 1'b0;
        lat_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (req && ack_i) begin
                    rd_done = ~we_i;
                    wr_done = we_i;
                    lat_upd = 1'b1;
                end else if (req) begin
                    adr_d   = adr_i;
                    we_d    = we_i;
                    lat_d   = LAT_ONE;
                    state_d = ST_WAIT;
                end else if (ack_i) begin
                    err_set[0] = 1'b1;
                end
            end
            ST_WAIT: begin
                if (req && ack_i) begin
                    rd_done = ~we_q;
                    wr_done = we_q;
                    lat_upd = 1'b1;
                    lat_val = lat_q;
                    lat_d   = '0;
                    state_d = ST_IDLE;
                end else if (!req) begin
                    // an ack arriving after the request vanished is treated as stray
                    if (ack_i) err_set[0] = 1'b1;
                    else       err_set[1] = 1'b1;
                    lat_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    if ((adr_i != adr_q) || (we_i != we_q)) err_set[3] = 1'b1;
                    lat_d = lat_q + LAT_ONE;
                    if (lat_q == LAT_LAST) begin
                        err_set[2] = 1'b1;
                        state_d    = ST_TOUT;
                    end
                end
            end
            ST_TOUT: begin
                if (ack_i || !req) begin
                    lat_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // clr_i clears the held value first, so an event in the same cycle still lands
    always_comb begin
        err_d     = (clr_i ? 4'b0000 : err_q) | err_set;
        irq_d     = |err_q;
        rd_cnt_d  = cnt_next(rd_cnt_q, rd_done, clr_i);
        wr_cnt_d  = cnt_next(wr_cnt_q, wr_done, clr_i);
        max_base  = clr_i ? '0 : max_lat_q;
        max_lat_d = (lat_upd && (lat_val > max_base)) ? lat_val : max_base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q     <= '0;
            irq_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            max_lat_q <= '0;
        end else begin
            err_q     <= err_d;
            irq_q     <= irq_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            max_lat_q <= max_lat_d;
        end
    end

    assign err_o     = err_q;
    assign irq_o     = irq_q;
    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign max_lat_o = max_lat_q;
    assign busy_o    = (state_q == ST_WAIT) || (state_q == ST_TOUT);

`ifdef WB_MON_ASSERT_EN
    a_stray_ack: assert property (@(posedge clk_i) disable iff (rst_i) !err_set[0])
        else $error("[WB_MON] stray ack without request");
    a_stb_drop: assert property (@(posedge clk_i) disable iff (rst_i) !err_set[1])
        else $error("[WB_MON] request dropped before ack");
    a_timeout: assert property (@(posedge clk_i) disable iff (rst_i) !err_set[2])
        else $error("[WB_MON] ack timeout");
    a_req_chg: assert property (@(posedge clk_i) disable iff (rst_i) !err_set[3])
        else $error("[WB_MON] address/we changed while request pending");

    c_rd_done: cover property (@(posedge clk_i) disable iff (rst_i) rd_done)
        $info("[WB_MON] read completed");
    c_wr_done: cover property (@(posedge clk_i) disable iff (rst_i) wr_done)
        $info("[WB_MON] write completed");
    c_tout: cover property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ST_WAIT) && (state_d == ST_TOUT))
        $info("[WB_MON] entered TOUT");
`endif

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed self-checking bench for wb_protocol_monitor (TIMEOUT=4, AW=24; second instance with CNT_W=2).
module tb_wb_protocol_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_i, stb_i, we_i, ack_i, clr_i;
    logic [23:0] adr_i;

    logic [3:0]  err_o, err2_o;
    logic        irq_o, irq2_o;
    logic [15:0] rd_cnt_o, wr_cnt_o;
    logic [1:0]  rd_cnt2_o, wr_cnt2_o;
    logic [2:0]  max_lat_o, max_lat2_o;
    logic        busy_o, busy2_o;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt;

    always #5 clk_i = ~clk_i;

    wb_protocol_monitor #(.AW(24), .TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .ack_i(ack_i), .clr_i(clr_i), .err_o(err_o), .irq_o(irq_o),
        .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .max_lat_o(max_lat_o), .busy_o(busy_o)
    );

    wb_protocol_monitor #(.AW(24), .TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .ack_i(ack_i), .clr_i(clr_i), .err_o(err2_o), .irq_o(irq2_o),
        .rd_cnt_o(rd_cnt2_o), .wr_cnt_o(wr_cnt2_o), .max_lat_o(max_lat2_o), .busy_o(busy2_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic c, input logic s, input logic w,
                         input logic [23:0] a, input logic k);
        cyc_i = c; stb_i = s; we_i = w; adr_i = a; ack_i = k;
    endtask

    task automatic idle_clr();
        drive(0, 0, 0, 24'h0, 0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        clr_i = 1'b0;
        drive(0, 0, 0, 24'h0, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        chk("rst_err",  32'(err_o), 32'h0);
        chk("rst_irq",  32'(irq_o), 32'h0);
        chk("rst_rd",   32'(rd_cnt_o), 32'h0);
        chk("rst_wr",   32'(wr_cnt_o), 32'h0);
        chk("rst_lat",  32'(max_lat_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);

        // single write, ack two cycles after request
        busy_cnt = 0;
        drive(1, 1, 1, 24'h000010, 0);
        tick(); busy_cnt += int'(busy_o);
        tick(); busy_cnt += int'(busy_o);
        ack_i = 1'b1;
        tick(); busy_cnt += int'(busy_o);
        drive(0, 0, 0, 24'h0, 0);
        tick(); busy_cnt += int'(busy_o);
        chk("wr1_cnt",  32'(wr_cnt_o), 32'd1);
        chk("wr1_lat",  32'(max_lat_o), 32'd2);
        chk("wr1_err",  32'(err_o), 32'h0);
        chk("wr1_busy", 32'(busy_cnt), 32'd2);

        // latency 1 after latency 2: max must hold
        drive(1, 1, 1, 24'h000020, 0);
        tick();
        ack_i = 1'b1;
        tick();
        drive(0, 0, 0, 24'h0, 0);
        chk("wr2_cnt", 32'(wr_cnt_o), 32'd2);
        chk("wr2_lat", 32'(max_lat_o), 32'd2);

        // stray ack
        drive(0, 0, 0, 24'h0, 1);
        tick();
        ack_i = 1'b0;
        chk("stray_err", 32'(err_o), 32'h1);
        chk("stray_irq_early", 32'(irq_o), 32'h0);
        tick();
        chk("stray_irq", 32'(irq_o), 32'h1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr_err", 32'(err_o), 32'h0);
        chk("clr_wr",  32'(wr_cnt_o), 32'h0);
        chk("clr_lat", 32'(max_lat_o), 32'h0);
        tick();
        chk("clr_irq", 32'(irq_o), 32'h0);

        // read held without ack -> timeout
        drive(1, 1, 0, 24'h000200, 0);
        tick(); tick(); tick();
        chk("tout_not_yet", 32'(err_o[2]), 32'h0);
        tick();
        chk("tout_err",  32'(err_o), 32'h4);
        chk("tout_busy", 32'(busy_o), 32'h1);
        ack_i = 1'b1;
        tick();
        drive(0, 0, 0, 24'h0, 0);
        chk("tout_exit", 32'(busy_o), 32'h0);
        chk("tout_rd",   32'(rd_cnt_o), 32'h0);
        chk("tout_lat",  32'(max_lat_o), 32'h0);
        idle_clr();

        // address change while pending
        drive(1, 1, 0, 24'h000100, 0);
        tick();
        adr_i = 24'h000104;
        tick();
        chk("chg_err", 32'(err_o), 32'h8);
        ack_i = 1'b1;
        tick();
        drive(0, 0, 0, 24'h0, 0);
        chk("chg_rd", 32'(rd_cnt_o), 32'd1);
        idle_clr();

        // strobe drop without ack
        drive(1, 1, 0, 24'h000300, 0);
        tick();
        stb_i = 1'b0;
        tick();
        drive(0, 0, 0, 24'h0, 0);
        chk("drop_err",  32'(err_o), 32'h2);
        chk("drop_rd",   32'(rd_cnt_o), 32'h0);
        chk("drop_busy", 32'(busy_o), 32'h0);
        idle_clr();

        // three back-to-back zero-wait writes
        drive(1, 1, 1, 24'h000400, 1);
        tick();
        adr_i = 24'h000404;
        tick();
        adr_i = 24'h000408;
        tick();
        drive(0, 0, 0, 24'h0, 0);
        chk("b2b_wr",   32'(wr_cnt_o), 32'd3);
        chk("b2b_lat",  32'(max_lat_o), 32'd0);
        chk("b2b_err",  32'(err_o), 32'h0);
        chk("b2b_busy", 32'(busy_o), 32'h0);

        // clear in the same cycle as a completion loads 1
        drive(1, 1, 1, 24'h000500, 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        drive(0, 0, 0, 24'h0, 0);
        chk("clr_evt_wr", 32'(wr_cnt_o), 32'd1);
        idle_clr();

        // five zero-wait reads: saturates the 2-bit instance
        drive(1, 1, 0, 24'h000600, 1);
        for (int i = 0; i < 5; i++) tick();
        drive(0, 0, 0, 24'h0, 0);
        chk("sat_rd2", 32'(rd_cnt2_o), 32'd3);
        chk("sat_rd",  32'(rd_cnt_o), 32'd5);

        // asynchronous reset in the middle of WAIT
        drive(1, 1, 0, 24'h000700, 0);
        tick();
        chk("mid_busy", 32'(busy_o), 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_rd",   32'(rd_cnt_o), 32'h0);
        chk("arst_rd2",  32'(rd_cnt2_o), 32'h0);
        chk("arst_err",  32'(err_o), 32'h0);
        chk("arst_irq",  32'(irq_o), 32'h0);
        chk("arst_lat",  32'(max_lat_o), 32'h0);
        drive(0, 0, 0, 24'h0, 0);
        #1;
        rst_i = 1'b0;
        tick();
        tick();
        chk("post_rst_err", 32'(err_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
